// File: rtl/bitcoin_target_compare.sv
// rtl/bitcoin_target_compare.sv - scans hasher h0 words against a difficulty target
// Optional result write-back enabled by TARGET_RESULT_WRITEBACK_EN.
module bitcoin_target_compare #(
  parameter int NUM_OF_NONCES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] hash_addr,
  input  logic [15:0] result_addr,
  input  logic [31:0] target,
  output logic        done,
  output logic        found,
  output logic [31:0] found_nonce,
  output logic [31:0] best_nonce,
  output logic [31:0] best_hash,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, READ, WB0, WB1} state_t;

  localparam logic [16:0] N = 17'(NUM_OF_NONCES);

  state_t      state;
  logic [16:0] j;
  logic [15:0] base;
  logic [31:0] tgt;

  logic        found_n;
  logic [31:0] found_nonce_n;
  logic [31:0] best_nonce_n;
  logic [31:0] best_hash_n;
  logic [31:0] nonce;

  assign done    = (state == IDLE);
  assign mem_clk = clk;

  // Word read back in READ cycle j belongs to nonce j-1.
  always_comb begin
    nonce         = 32'(j - 17'd1);
    found_n       = found;
    found_nonce_n = found_nonce;
    best_nonce_n  = best_nonce;
    best_hash_n   = best_hash;
    if (!found && (mem_read_data < tgt)) begin
      found_n       = 1'b1;
      found_nonce_n = nonce;
    end
    if ((j == 17'd1) || (mem_read_data < best_hash)) begin
      best_hash_n  = mem_read_data;
      best_nonce_n = nonce;
    end
  end

`ifdef TARGET_RESULT_WRITEBACK_EN
  logic [15:0] rbase;
`else
  logic unused_result_addr;
  assign unused_result_addr = ^result_addr;
  assign mem_we             = 1'b0;
  assign mem_write_data     = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      j           <= '0;
      base        <= '0;
      tgt         <= '0;
      found       <= 1'b0;
      found_nonce <= '0;
      best_nonce  <= '0;
      best_hash   <= 32'hFFFF_FFFF;
      mem_addr    <= '0;
`ifdef TARGET_RESULT_WRITEBACK_EN
      rbase          <= '0;
      mem_we         <= 1'b0;
      mem_write_data <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            tgt         <= target;
            base        <= hash_addr;
            found       <= 1'b0;
            found_nonce <= '0;
            best_nonce  <= '0;
            best_hash   <= 32'hFFFF_FFFF;
            j           <= '0;
            mem_addr    <= hash_addr;
`ifdef TARGET_RESULT_WRITEBACK_EN
            rbase       <= result_addr;
`endif
            state       <= READ;
          end
        end
        READ: begin
          if (j != 17'd0) begin
            found       <= found_n;
            found_nonce <= found_nonce_n;
            best_nonce  <= best_nonce_n;
            best_hash   <= best_hash_n;
          end
          if ((j + 17'd1) < N)
            mem_addr <= base + j[15:0] + 16'd1;
          if (j == N) begin
`ifdef TARGET_RESULT_WRITEBACK_EN
            mem_we         <= 1'b1;
            mem_addr       <= rbase;
            mem_write_data <= {found_n, found_nonce_n[30:0]};
            state          <= WB0;
`else
            state          <= IDLE;
`endif
          end else begin
            j <= j + 17'd1;
          end
        end
`ifdef TARGET_RESULT_WRITEBACK_EN
        WB0: begin
          mem_addr       <= rbase + 16'd1;
          mem_write_data <= best_hash;
          state          <= WB1;
        end
        WB1: begin
          mem_we <= 1'b0;
          state  <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitcoin_target_compare.sv
// tb/tb_bitcoin_target_compare.sv - directed and random checks of bitcoin_target_compare
module tb_bitcoin_target_compare;

  localparam int N = 16;
`ifdef TARGET_RESULT_WRITEBACK_EN
  localparam int LAT = N + 4;
  localparam int WE_CYC = 2;
`else
  localparam int LAT = N + 2;
  localparam int WE_CYC = 0;
`endif

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] hash_addr, result_addr;
  logic [31:0] target;
  logic        done, found, mem_clk, mem_we;
  logic [31:0] found_nonce, best_nonce, best_hash, mem_write_data, mem_read_data;
  logic [15:0] mem_addr;

  logic [31:0] mem [0:65535];
  logic        fill_we;
  logic [15:0] fill_addr;
  logic [31:0] fill_data;

  int total = 0;
  int bad   = 0;

  bitcoin_target_compare #(.NUM_OF_NONCES(N)) dut (
    .clk(clk), .reset(reset), .start(start), .hash_addr(hash_addr),
    .result_addr(result_addr), .target(target), .done(done), .found(found),
    .found_nonce(found_nonce), .best_nonce(best_nonce), .best_hash(best_hash),
    .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fill_we) mem[fill_addr] <= fill_data;
    else if (mem_we) mem[mem_addr] <= mem_write_data;
    mem_read_data <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [15:0] a, input logic [31:0] d);
    fill_we = 1'b1; fill_addr = a; fill_data = d;
    @(negedge clk);
    fill_we = 1'b0;
  endtask

  // Reference: first index with h < tgt, and the strictly smallest h (lowest index on ties).
  task automatic model(input logic [15:0] b, input logic [31:0] tgt,
                       output logic [31:0] f, output logic [31:0] fn,
                       output logic [31:0] bn, output logic [31:0] bh);
    logic [31:0] h;
    f = 0; fn = 0; bn = 0; bh = 32'hFFFF_FFFF;
    for (int k = 0; k < N; k++) begin
      h = mem[b + 16'(k)];
      if (f == 0 && h < tgt) begin f = 1; fn = 32'(k); end
      if (k == 0 || h < bh) begin bh = h; bn = 32'(k); end
    end
  endtask

  task automatic run_scan(input logic [15:0] b, input logic [31:0] tgt, input bit mid_pulse,
                          output int cycles, output int we_cycles);
    hash_addr = b; target = tgt; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cycles = 1; we_cycles = 0;
    while (!done && cycles < 1000) begin
      if (mem_we) we_cycles++;
      if (mid_pulse && cycles == 5) begin start = 1'b1; target = 32'hFFFF_FFFF; end
      else start = 1'b0;
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
  endtask

  task automatic check_scan(input string tag, input logic [15:0] b, input logic [31:0] tgt,
                            input bit mid_pulse);
    int cyc, wec;
    logic [31:0] f, fn, bn, bh;
    model(b, tgt, f, fn, bn, bh);
    run_scan(b, tgt, mid_pulse, cyc, wec);
    chk({tag, ".latency"}, 32'(cyc), 32'(LAT));
    chk({tag, ".we_cycles"}, 32'(wec), 32'(WE_CYC));
    chk({tag, ".found"}, {31'b0, found}, f);
    chk({tag, ".found_nonce"}, found_nonce, fn);
    chk({tag, ".best_nonce"}, best_nonce, bn);
    chk({tag, ".best_hash"}, best_hash, bh);
  endtask

  initial begin
    int cyc, wec;
    logic [15:0] b;
    logic [31:0] t;

    reset = 1'b1; start = 1'b0; hash_addr = 16'h0100; result_addr = 16'h0200;
    target = '0; fill_we = 1'b0; fill_addr = '0; fill_data = '0;
    for (int a = 0; a < 65536; a++) mem[a] = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset.done", {31'b0, done}, 32'd1);
    chk("reset.found", {31'b0, found}, 32'd0);
    chk("reset.found_nonce", found_nonce, 32'd0);
    chk("reset.best_nonce", best_nonce, 32'd0);
    chk("reset.best_hash", best_hash, 32'hFFFF_FFFF);
    chk("reset.mem_we", {31'b0, mem_we}, 32'd0);
    chk("reset.mem_addr", {16'b0, mem_addr}, 32'd0);
    chk("reset.mem_write_data", mem_write_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Descending words; target one above nonce 11's word.
    for (int k = 0; k < N; k++) fill(16'h0100 + 16'(k), 32'hF000_0000 - 32'(k));
    run_scan(16'h0100, 32'hEFFF_FFF6, 1'b0, cyc, wec);
    chk("s1.latency", 32'(cyc), 32'(LAT));
    chk("s1.found", {31'b0, found}, 32'd1);
    chk("s1.found_nonce", found_nonce, 32'd11);
    chk("s1.best_nonce", best_nonce, 32'd15);
    chk("s1.best_hash", best_hash, 32'hEFFF_FFF1);
`ifdef TARGET_RESULT_WRITEBACK_EN
    chk("s6.wb0", mem[16'h0200], 32'h8000_000B);
    chk("s6.wb1", mem[16'h0201], 32'hEFFF_FFF1);
    chk("s6.we_cycles", 32'(wec), 32'd2);
`endif
    // Target equal to nonce 11's word: strict compare moves the hit to nonce 12.
    check_scan("s1strict", 16'h0100, 32'hEFFF_FFF5, 1'b0);

    for (int k = 0; k < N; k++) fill(16'h0100 + 16'(k), 32'h1234_5678);
    run_scan(16'h0100, 32'h1234_5678, 1'b0, cyc, wec);
    chk("s2.found", {31'b0, found}, 32'd0);
    chk("s2.found_nonce", found_nonce, 32'd0);
    chk("s2.best_nonce", best_nonce, 32'd0);
    chk("s2.best_hash", best_hash, 32'h1234_5678);

    for (int k = 0; k < N; k++) fill(16'hFFF8 + 16'(k), 32'h8000_0000 + 32'(k));
    fill(16'h0003, 32'h0000_0001);
    run_scan(16'hFFF8, 32'h0000_0002, 1'b0, cyc, wec);
    chk("s3.found", {31'b0, found}, 32'd1);
    chk("s3.found_nonce", found_nonce, 32'd11);
    chk("s3.best_nonce", best_nonce, 32'd11);
    chk("s3.best_hash", best_hash, 32'd1);

    // Reset in READ cycle 7 after an early hit has already registered.
    for (int k = 0; k < N; k++) fill(16'h0100 + 16'(k), 32'hF000_0000 - 32'(k));
    hash_addr = 16'h0100; target = 32'hF000_0000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    chk("s4.pre_found", {31'b0, found}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("s4.done", {31'b0, done}, 32'd1);
    chk("s4.found", {31'b0, found}, 32'd0);
    chk("s4.best_hash", best_hash, 32'hFFFF_FFFF);
    chk("s4.mem_we", {31'b0, mem_we}, 32'd0);
    chk("s4.mem_addr", {16'b0, mem_addr}, 32'd0);
    check_scan("s4restart", 16'h0100, 32'hF000_0000, 1'b0);

    check_scan("s5", 16'h0100, 32'hEFFF_FFF6, 1'b1);

    for (int k = 0; k < N; k++) fill(16'h0300 + 16'(k), 32'hFFFF_FFFF);
    check_scan("allff", 16'h0300, 32'hFFFF_FFFF, 1'b0);

    for (int it = 0; it < 8; it++) begin
      b = 16'($urandom);
      if (b >= 16'h01F0 && b < 16'h0210) b = 16'h0400;
      for (int k = 0; k < N; k++)
        fill(b + 16'(k), (it % 3 == 0) ? 32'($urandom_range(0, 3)) : $urandom);
      if (it == 1) t = 32'h0;
      else if (it % 3 == 0) t = 32'($urandom_range(0, 4));
      else t = $urandom;
      check_scan($sformatf("rand%0d", it), b, t, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
